lsu_axi_master: RTL and testbench

- Parametrised load/store unit between the core's execute/writeback stage and an AXI4-Lite data port.
- Accepts one memory request at a time over a valid/ready request channel and issues the matching AXI-Lite read or write.
- Aligns byte lanes from the address offset, sign- or zero-extends load data, and returns a response with an error code.
- Generalises the single-width 32-bit LSU to DATA_W in {32, 64}, adds address outputs, lane steering, misalignment and bus-error reporting, and concurrent AW/W issue.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_axi_master_lane_align.sv | 44 ++++
 rtl/lsu_axi_master.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU AXI4-Lite master: FSM states,
// access sizes, response error codes and the misalignment helper.
package lsu_pkg;

    typedef enum logic [2:0] {IDLE, AR, R, WR, B, RSP} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_BUS      = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;
    localparam logic [1:0] ERR_SIZE     = 2'd3;

    localparam logic [1:0] OKAY = 2'b00;

    // An access is aligned when the address is a multiple of its byte count.
    function automatic logic is_misaligned(input logic [2:0] lo, input logic [1:0] size);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            SZ_W:    return |lo[1:0];
            default: return |lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_axi_master_lane_align.sv
// Combinational byte-lane steering: store data/strobe shift by address offset
// and load data shift, truncation and sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] i_off,
    input  logic [1:0]                  i_size,
    input  logic                        i_sext,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [DATA_W-1:0]           i_rdata,
    output logic [DATA_W-1:0]           o_wdata,
    output logic [DATA_W/8-1:0]         o_wstrb,
    output logic [DATA_W-1:0]           o_rdata
);
    localparam int NB = DATA_W / 8;

    logic [3:0]        w_nbytes;
    logic [NB-1:0]     w_mask;
    logic [DATA_W-1:0] w_sh;

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input logic [3:0] nbytes,
                                                 input logic sext);
        int msb;
        msb = 8 * int'(nbytes) - 1;
        if (msb > DATA_W - 1) msb = DATA_W - 1;
        for (int i = 0; i < DATA_W; i++)
            extend[i] = (i <= msb) ? v[i] : (sext & v[msb]);
    endfunction

    always_comb begin
        w_nbytes = 4'd1 << i_size;
        w_mask   = '0;
        for (int i = 0; i < NB; i++)
            w_mask[i] = (i < int'(w_nbytes));
        o_wstrb = w_mask << i_off;
        o_wdata = i_wdata << {i_off, 3'b000};
        w_sh    = i_rdata >> {i_off, 3'b000};
        o_rdata = extend(w_sh, w_nbytes, i_sext);
    end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding load/store unit driving an AXI4-Lite data port.
// Optional perf counters are enabled with `define LSU_PERF_CNT_EN.
module lsu_axi_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NB     = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [NB-1:0]     wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_stall
`endif
);
    localparam int OFF_W = $clog2(NB);

    state_t            r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [OFF_W-1:0]  r_off;

    logic              w_accept;
    logic              w_illegal;
    logic              w_misal;
    logic [ADDR_W-1:0] w_addr_al;
    logic [OFF_W-1:0]  w_off;
    logic [1:0]        w_size;
    logic [DATA_W-1:0] w_wdata_sh;
    logic [NB-1:0]     w_wstrb;
    logic [DATA_W-1:0] w_rdata_ext;
    logic              w_aw_done;
    logic              w_w_done;

    assign w_accept  = req_valid & req_ready;
    assign w_illegal = (DATA_W == 32) && (req_size == SZ_D);
    assign w_misal   = is_misaligned(req_addr[2:0], req_size);
    assign w_addr_al = req_addr & ~ADDR_W'(NB - 1);
    assign w_aw_done = ~awvalid | awready;
    assign w_w_done  = ~wvalid | wready;

    // Store steering uses the live request in IDLE; load extension uses the captured request.
    assign w_off  = (r_state == IDLE) ? req_addr[OFF_W-1:0] : r_off;
    assign w_size = (r_state == IDLE) ? req_size : r_size;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_off   (w_off),
        .i_size  (w_size),
        .i_sext  (r_sext),
        .i_wdata (req_wdata),
        .i_rdata (rdata),
        .o_wdata (w_wdata_sh),
        .o_wstrb (w_wstrb),
        .o_rdata (w_rdata_ext)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_size    <= SZ_B;
            r_sext    <= 1'b0;
            r_off     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_we      <= req_we;
                    r_size    <= req_size;
                    r_sext    <= req_sext;
                    r_off     <= req_addr[OFF_W-1:0];
                    req_ready <= 1'b0;
                    if (w_illegal || w_misal) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= w_illegal ? ERR_SIZE : ERR_MISALIGN;
                        r_state   <= RSP;
                    end else if (req_we) begin
                        awaddr  <= w_addr_al;
                        awvalid <= 1'b1;
                        wdata   <= w_wdata_sh;
                        wstrb   <= w_wstrb;
                        wvalid  <= 1'b1;
                        r_state <= WR;
                    end else begin
                        araddr  <= w_addr_al;
                        arvalid <= 1'b1;
                        r_state <= AR;
                    end
                end
                AR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    r_state <= R;
                end
                R: if (rvalid) begin
                    rready    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= (rresp == OKAY) ? ERR_OK : ERR_BUS;
                    rsp_rdata <= (rresp == OKAY) ? w_rdata_ext : '0;
                    r_state   <= RSP;
                end
                WR: begin
                    if (w_aw_done && w_w_done) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b0;
                        bready  <= 1'b1;
                        r_state <= B;
                    end else begin
                        awvalid <= awvalid & ~awready;
                        wvalid  <= wvalid & ~wready;
                    end
                end
                B: if (bvalid) begin
                    bready    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= (bresp == OKAY) ? ERR_OK : ERR_BUS;
                    rsp_rdata <= '0;
                    r_state   <= RSP;
                end
                RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    logic w_hs;
    logic w_busy;

    always_comb begin
        w_hs   = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            AR: begin w_busy = 1'b1; w_hs = arvalid & arready; end
            R:  begin w_busy = 1'b1; w_hs = rready & rvalid; end
            WR: begin w_busy = 1'b1; w_hs = (awvalid & awready) | (wvalid & wready); end
            B:  begin w_busy = 1'b1; w_hs = bvalid & bready; end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_stall  <= '0;
        end else begin
            if (rsp_valid && rsp_ready && rsp_err == ERR_OK) begin
                if (r_we) perf_stores <= perf_stores + 32'd1;
                else      perf_loads  <= perf_loads + 32'd1;
            end
            if (w_busy && !w_hs) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed self-checking bench for lsu_axi_master (DATA_W = 32).
module tb_lsu_axi_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_stall;
`endif

    int nchk = 0;
    int nerr = 0;
    int awcnt, wcnt;

    always #5 clock = ~clock;

    lsu_axi_master dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef LSU_PERF_CNT_EN
        ,
        .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall(perf_stall)
`endif
    );

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns at the first cycle after acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
        req_addr = addr; req_wdata = wd;
        tick();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 0; req_we = 0; req_size = 0; req_sext = 0;
        req_addr = 0; req_wdata = 0; rsp_ready = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, rsp_valid}, 0);
        chk("rst_rsp", {rsp_rdata, rsp_err}, 0);
        chk("rst_addr", {araddr, awaddr}, 0);
        chk("rst_wdata_wstrb", {wdata, wstrb}, 0);
        reset = 1'b0;
        tick();

        // Load byte, sign-extended, offset 3, immediate slave
        arready = 1; rvalid = 1; rdata = 32'h8012_3456; rresp = 2'b00;
        issue(0, 2'd0, 1, 32'h8000_0003, 0);
        chk("ld_b_arvalid", arvalid, 1);
        chk("ld_b_araddr", araddr, 32'h8000_0000);
        chk("ld_b_req_ready", req_ready, 0);
        tick();
        chk("ld_b_rready", {rready, arvalid}, 2'b10);
        tick();
        chk("ld_b_rsp_valid_at3", rsp_valid, 1);
        chk("ld_b_rdata", rsp_rdata, 32'hFFFF_FF80);
        chk("ld_b_err", rsp_err, 0);
        finish_rsp();
        chk("ld_b_done", {rsp_valid, req_ready}, 2'b01);

        // Load half, unsigned, offset 2
        rdata = 32'hABCD_0000;
        issue(0, 2'd1, 0, 32'h8000_0002, 0);
        repeat (2) tick();
        chk("ld_h_rdata", rsp_rdata, 32'h0000_ABCD);
        finish_rsp();

        // Store half at offset 2, immediate slave
        arready = 0; rvalid = 0;
        awready = 1; wready = 1; bvalid = 1; bresp = 0;
        issue(1, 2'd1, 0, 32'h8000_0002, 32'h0000_1234);
        chk("st_h_aw_w_same", {awvalid, wvalid}, 2'b11);
        chk("st_h_awaddr", awaddr, 32'h8000_0000);
        chk("st_h_wdata", wdata, 32'h1234_0000);
        chk("st_h_wstrb", wstrb, 4'b1100);
        tick();
        chk("st_h_bready", {bready, awvalid, wvalid}, 3'b100);
        tick();
        chk("st_h_rsp", {rsp_valid, rsp_err}, 3'b100);
        chk("st_h_rdata0", rsp_rdata, 0);
        finish_rsp();

        // Store word with awready delayed three cycles
        awready = 0; wready = 1;
        issue(1, 2'd2, 0, 32'h8000_0010, 32'hCAFE_F00D);
        awcnt = 0; wcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) awready = 1;
            awcnt += int'(awvalid);
            wcnt  += int'(wvalid);
            chk("st_dly_no_bready", bready, 0);
            tick();
        end
        chk("st_dly_awcnt", awcnt, 4);
        chk("st_dly_wcnt", wcnt, 1);
        chk("st_dly_bready", {bready, awvalid, wvalid}, 3'b100);
        tick();
        chk("st_dly_rsp", {rsp_valid, rsp_err, bready}, 4'b1000);
        finish_rsp();

        // Misaligned word load and illegal dword size: no bus traffic
        awready = 0; wready = 0; bvalid = 0; arready = 1; rvalid = 1;
        issue(0, 2'd2, 0, 32'h8000_0002, 0);
        chk("misal_rsp", {rsp_valid, rsp_err}, 3'b110);
        chk("misal_no_ar", arvalid, 0);
        finish_rsp();
        chk("misal_no_ar2", arvalid, 0);
        issue(0, 2'd3, 0, 32'h8000_0000, 0);
        chk("size_rsp", {rsp_valid, rsp_err}, 3'b111);
        chk("size_no_ar", arvalid, 0);
        finish_rsp();

        // Bus error on load with consumer stalling for five cycles
        rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        issue(0, 2'd2, 0, 32'h8000_0004, 0);
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            chk("berr_hold", {rsp_valid, rsp_err, req_ready}, 4'b1010);
            chk("berr_rdata0", rsp_rdata, 0);
            tick();
        end
        finish_rsp();
        chk("berr_release", {rsp_valid, req_ready}, 2'b01);
        rresp = 2'b00; arready = 0; rvalid = 0;

        // Reset while waiting in B
        awready = 1; wready = 1; bvalid = 0;
        issue(1, 2'd0, 0, 32'h8000_0001, 32'h55);
        chk("rst_b_wstrb", wstrb, 4'b0010);
        tick();
        chk("rst_b_inB", bready, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_b_req_ready", req_ready, 1);
        chk("rst_b_valids", {arvalid, rready, awvalid, wvalid, bready, rsp_valid}, 0);
`ifdef LSU_PERF_CNT_EN
        chk("rst_b_perf", {perf_loads, perf_stores}, 0);
        chk("rst_b_stall", perf_stall, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
